sequencer: RTL and testbench
============================

# sequencer

Byte sequencer. On an enable request it captures a 32-bit word and a byte count `n`, then emits `n` bytes of that word on `Sequence`, one byte per clock, wrapping over the four bytes as needed. It then raises `Seq_done`. It sits between a word-producing control block and a byte-wide downstream consumer.

## Interface
- No parameters; all widths are fixed.
- `clk`  in  1  rising-edge clock; sole clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `Seq_en`  in  1  level request; sequencing runs while high, and deasserting aborts or re-arms.
- `n`  in  8  number of bytes to emit (0–255); sampled only at start.
- `in`  in  32  source word; sampled only at start.
- `Seq_done`  out  1  registered; high while in DONE.
- `Sequence`  out  8  registered output byte; 0 when not in RUN.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `Seq_en`=1 at an edge: latch `in` into `word_q` and `n` into `cnt_q`, and clear `idx`.
  - If `n`≠0: go to RUN and load `Sequence` with byte 0.
  - If `n`=0: go directly to DONE.
- **RUN**
  - Each edge advances `idx` (2-bit, wraps 3→0) and loads the next byte.
  - After `n` bytes have been presented, go to DONE.
  - `Seq_en`=0 at any edge in RUN: abort to IDLE, `Sequence`=0, no `Seq_done`.
- **DONE**
  - `Seq_done`=1, `Sequence`=0.
  - Stay until `Seq_en`=0, then go to IDLE.
  - There is no auto-restart while `Seq_en` stays high.
- Byte order is LSB-first by default: byte k = `word_q[8*(k mod 4) +: 8]`.
- Internal byte counter is 8 bits. It counts presented bytes and compares against `cnt_q`; there is no overflow at `n`=255.
- Changes on `in`/`n` after start have no effect until the next start.

## Timing
- Reset (`rst`=0, async): state IDLE, `Sequence`=0, `Seq_done`=0, internal registers cleared. Reset mid-RUN aborts immediately.
- Start edge E0 (IDLE, `Seq_en`=1): byte 0 is visible after E0.
- Byte k is visible after edge Ek.
- The last byte is visible after E(n−1).
- After En: DONE, so `Seq_done`=1 and `Sequence`=0.
- `n`=0: `Seq_done`=1 after E0.
- DONE→IDLE on the first edge with `Seq_en`=0. A new start needs `Seq_en` to return to 1 at a later edge.
- `Seq_done` lasts at least one cycle and stays high for as long as `Seq_en` is held high.

## Configuration
- `SEQUENCER_MSB_FIRST_EN`
  - Defined: byte k = `word_q[8*(3−(k mod 4)) +: 8]`, i.e. MSB-first, wrapping 3,2,1,0,3,…
  - Undefined (default): LSB-first order as above.
  - All other timing is identical.

## Structure
- Package `sequencer_pkg`:
  - state enum `seq_state_t` {IDLE, RUN, DONE}
  - `SEQ_WORD_W`=32, `SEQ_BYTE_W`=8, `SEQ_CNT_W`=8, `SEQ_BYTES_PER_WORD`=4
- Sub-module `seq_byte_sel`: combinational 4:1 byte mux from `word_q` and `idx`. The macro-controlled byte order lives here.
- Top: FSM, counter, and output registers.

## Test plan
- Reset then `n`=3, `in`=32'hABCDEFAB, `Seq_en`=1 held → `Sequence` AB, EF, CD on consecutive cycles → `Seq_done`=1 and `Sequence`=0 for as long as `Seq_en` stays high; no restart.
- `n`=6, `in`=32'h11223344 → 44,33,22,11,44,33 (wrap), then done. With `SEQUENCER_MSB_FIRST_EN`: 11,22,33,44,11,22.
- `n`=0 → `Seq_done`=1 one cycle after start; `Sequence` stays 0.
- Drop `Seq_en` after 2 bytes of an `n`=5 run → IDLE next edge, `Sequence`=0, `Seq_done` never asserts. Reassert → fresh run from byte 0.
- Change `in`/`n` mid-run → emitted bytes still come from the latched values.
- Assert `rst`=0 asynchronously mid-RUN → outputs 0 immediately. After release, with `Seq_en` held, a new run starts.

Source files
------------

// File: rtl/sequencer_pkg.sv
// Shared types and widths for the byte sequencer.
package sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int SEQ_WORD_W         = 32;
  localparam int SEQ_BYTE_W         = 8;
  localparam int SEQ_CNT_W          = 8;
  localparam int SEQ_BYTES_PER_WORD = 4;
  localparam int SEQ_IDX_W          = $clog2(SEQ_BYTES_PER_WORD);

endpackage

// File: rtl/sequencer_byte_sel.sv
// Combinational byte picker for the sequencer; SEQUENCER_MSB_FIRST_EN selects
// MSB-first lane order, otherwise bytes come out LSB-first.
module seq_byte_sel
  import sequencer_pkg::*;
(
  input  logic [SEQ_WORD_W-1:0] word,
  input  logic [SEQ_IDX_W-1:0]  idx,
  output logic [SEQ_BYTE_W-1:0] sel_byte
);

  logic [SEQ_IDX_W-1:0] lane;
  logic [SEQ_BYTE_W-1:0] lanes [SEQ_BYTES_PER_WORD];

`ifdef SEQUENCER_MSB_FIRST_EN
  assign lane = ~idx;
`else
  assign lane = idx;
`endif

  for (genvar gi = 0; gi < SEQ_BYTES_PER_WORD; gi++) begin : g_lane
    assign lanes[gi] = word[SEQ_BYTE_W*gi +: SEQ_BYTE_W];
  end

  assign sel_byte = lanes[lane];

endmodule

// File: rtl/sequencer.sv
// Byte sequencer: latches a word and count on start, emits that many bytes
// (wrapping across the word), then holds Seq_done until Seq_en drops.
module sequencer
  import sequencer_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Seq_en,
  input  logic [SEQ_CNT_W-1:0]  n,
  input  logic [SEQ_WORD_W-1:0] in,
  output logic                  Seq_done,
  output logic [SEQ_BYTE_W-1:0] Sequence
);

  seq_state_t            state_reg, state_next;
  logic [SEQ_WORD_W-1:0] word_reg, word_next;
  logic [SEQ_CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SEQ_CNT_W-1:0]  sent_reg, sent_next;
  logic [SEQ_IDX_W-1:0]  idx_reg, idx_next;
  logic [SEQ_BYTE_W-1:0] seq_reg, seq_next;
  logic                  done_reg, done_next;

  logic [SEQ_WORD_W-1:0] sel_word;
  logic [SEQ_IDX_W-1:0]  sel_idx;
  logic [SEQ_BYTE_W-1:0] sel_byte;

  // On the start edge the word is not latched yet, so byte 0 comes straight from in.
  assign sel_word = (state_reg == IDLE) ? in : word_reg;
  assign sel_idx  = (state_reg == IDLE) ? '0 : idx_reg + 1'b1;

  seq_byte_sel u_byte_sel (
    .word     (sel_word),
    .idx      (sel_idx),
    .sel_byte (sel_byte)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      cnt_reg   <= '0;
      sent_reg  <= '0;
      idx_reg   <= '0;
      seq_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      cnt_reg   <= cnt_next;
      sent_reg  <= sent_next;
      idx_reg   <= idx_next;
      seq_reg   <= seq_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    cnt_next   = cnt_reg;
    sent_next  = sent_reg;
    idx_next   = idx_reg;
    seq_next   = '0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (Seq_en) begin
          word_next = in;
          cnt_next  = n;
          idx_next  = '0;
          sent_next = SEQ_CNT_W'(1);
          if (n != '0) begin
            state_next = RUN;
            seq_next   = sel_byte;
          end else begin
            state_next = DONE;
            done_next  = 1'b1;
          end
        end
      end
      RUN: begin
        if (!Seq_en) begin
          state_next = IDLE;
        end else if (sent_reg == cnt_reg) begin
          state_next = DONE;
          done_next  = 1'b1;
        end else begin
          seq_next  = sel_byte;
          idx_next  = idx_reg + 1'b1;
          sent_next = sent_reg + 1'b1;
        end
      end
      DONE: begin
        if (!Seq_en) state_next = IDLE;
        else         done_next  = 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end

  assign Sequence = seq_reg;
  assign Seq_done = done_reg;

endmodule

// File: tb/tb_sequencer.sv
// Directed self-checking bench for sequencer; expected byte lists follow
// SEQUENCER_MSB_FIRST_EN when it is defined.
module tb_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Seq_en = 1'b0;
  logic [7:0]  n = '0;
  logic [31:0] in_w = '0;
  logic        Seq_done;
  logic [7:0]  Sequence;

  int total = 0;
  int passed = 0;

`ifdef SEQUENCER_MSB_FIRST_EN
  logic [7:0] t1_exp [3] = '{8'hAB, 8'hCD, 8'hEF};
  logic [7:0] t2_exp [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22};
  logic [7:0] t4_exp [5] = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'hA1};
  logic [7:0] t6_exp [2] = '{8'h55, 8'h66};
`else
  logic [7:0] t1_exp [3] = '{8'hAB, 8'hEF, 8'hCD};
  logic [7:0] t2_exp [6] = '{8'h44, 8'h33, 8'h22, 8'h11, 8'h44, 8'h33};
  logic [7:0] t4_exp [5] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'hD4};
  logic [7:0] t6_exp [2] = '{8'h88, 8'h77};
`endif

  sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .Seq_en   (Seq_en),
    .n        (n),
    .in       (in_w),
    .Seq_done (Seq_done),
    .Sequence (Sequence)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) begin
      passed++;
      $display("check %s: observed %0h expected %0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] seq_exp, input logic done_exp);
    check({tag, "_seq"}, {24'h0, Sequence}, {24'h0, seq_exp});
    check({tag, "_done"}, {31'h0, Seq_done}, {31'h0, done_exp});
  endtask

  initial begin
    // Reset values before any edge and across a couple of edges.
    #2;
    check_out("reset", 8'h00, 1'b0);
    tick();
    tick();
    check_out("reset_held", 8'h00, 1'b0);
    #2 rst = 1'b1;
    tick();

    // n=3 held high: three bytes, then DONE held, no restart.
    n = 8'd3; in_w = 32'hABCDEFAB; Seq_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("t1_b%0d", k), t1_exp[k], 1'b0);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      check_out($sformatf("t1_done%0d", k), 8'h00, 1'b1);
    end
    Seq_en = 1'b0;
    tick();
    check_out("t1_idle", 8'h00, 1'b0);

    // n=6 wraps around the word.
    n = 8'd6; in_w = 32'h11223344; Seq_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_out($sformatf("t2_b%0d", k), t2_exp[k], 1'b0);
    end
    tick();
    check_out("t2_done", 8'h00, 1'b1);
    Seq_en = 1'b0;
    tick();
    check_out("t2_idle", 8'h00, 1'b0);

    // n=0 goes straight to DONE.
    n = 8'd0; in_w = 32'hDEADBEEF; Seq_en = 1'b1;
    tick();
    check_out("t3_done", 8'h00, 1'b1);
    tick();
    check_out("t3_hold", 8'h00, 1'b1);
    Seq_en = 1'b0;
    tick();
    check_out("t3_idle", 8'h00, 1'b0);

    // Abort after two bytes of an n=5 run.
    n = 8'd5; in_w = 32'hA1B2C3D4; Seq_en = 1'b1;
    tick();
    check_out("t4_b0", t4_exp[0], 1'b0);
    tick();
    check_out("t4_b1", t4_exp[1], 1'b0);
    Seq_en = 1'b0;
    tick();
    check_out("t4_abort", 8'h00, 1'b0);
    tick();
    check_out("t4_abort_idle", 8'h00, 1'b0);

    // Fresh run; in/n change after start must not matter.
    Seq_en = 1'b1;
    tick();
    check_out("t5_b0", t4_exp[0], 1'b0);
    n = 8'd1; in_w = 32'hFFFFFFFF;
    for (int k = 1; k < 5; k++) begin
      tick();
      check_out($sformatf("t5_b%0d", k), t4_exp[k], 1'b0);
    end
    tick();
    check_out("t5_done", 8'h00, 1'b1);
    Seq_en = 1'b0;
    tick();
    check_out("t5_idle", 8'h00, 1'b0);

    // Asynchronous reset mid-RUN, then restart with Seq_en held.
    n = 8'd4; in_w = 32'h55667788; Seq_en = 1'b1;
    tick();
    check_out("t6_b0", t6_exp[0], 1'b0);
    tick();
    check_out("t6_b1", t6_exp[1], 1'b0);
    #2 rst = 1'b0;
    #1;
    check_out("t6_async_rst", 8'h00, 1'b0);
    #2 rst = 1'b1;
    tick();
    check_out("t6_restart_b0", t6_exp[0], 1'b0);
    tick();
    check_out("t6_restart_b1", t6_exp[1], 1'b0);
    Seq_en = 1'b0;
    tick();
    check_out("t6_idle", 8'h00, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
